conv_encoder_k7: RTL
====================

// Module: conv_encoder_k7
// PURPOSE
//   Rate-1/2 feed-forward convolutional encoder matching the 64-state Viterbi decoder datapath.
//   - Accepts one info bit per handshake and emits one coded pair per bit.
//   - The pair bit order is identical to the decoder's rx_pair input.
//   - Frames are delimited by in_last. Optional zero-tail termination returns the encoder to state 0.
// PARAMETERS
//   K   7        constraint length; the state register holds K-1 = 6 bits
//   G0  7'o171   generator for out_pair[1]; MSB taps the current input bit
//   G1  7'o133   generator for out_pair[0]; MSB taps the current input bit
// PORTS
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  in_bit/in_last valid
//   in_ready   out  1  encoder accepts the input this cycle
//   in_bit     in   1  information bit
//   in_last    in   1  last info bit of the frame
//   out_valid  out  1  out_pair valid (registered)
//   out_ready  in   1  downstream accepts out_pair
//   out_pair   out  2  coded pair {c0,c1}: [1] = parity(G0 & {u,sr}), [0] = parity(G1 & {u,sr})
//   out_last   out  1  final pair of the frame (including tail)
// BEHAVIOUR
//   - Reset values: out_valid=0, out_pair=2'b00, out_last=0, sr=0, FSM=DATA. in_ready follows combinationally.
//   - Shift register sr[K-2:0]; sr[K-2] is the most recent bit.
//     - The input vector is {u, sr[K-2:0]}.
//     - On each encode step: sr <= {u, sr[K-2:1]}.
//   - Output stage is a single register; no combinational path from in_* to out_*.
//     - advance = !out_valid || out_ready.
//     - When advance is high and a pair is produced, the output loads it in the same edge: out_valid=1, latency 1 clk.
//     - When advance is high and nothing is produced, out_valid <= 0.
//   - While out_valid && !out_ready: out_pair, out_last and sr hold stable; in_ready=0.
//   - FSM states:
//     - DATA: in_ready = advance.
//       - On in_valid && in_ready, encode u = in_bit.
//       - If in_last, go to TAIL (with TAIL_EN) or stay in DATA.
//     - TAIL: in_ready = 0.
//       - Encode u=0 on each advance; tail_cnt counts K-1 = 6 steps.
//       - On the 6th step, out_last=1, sr returns to 0, and the FSM goes to DATA.
//   - Without TAIL_EN:
//     - out_last = in_last of the encoded bit.
//     - sr is cleared to 0 at the same edge the last bit is encoded, so the next frame starts in state 0.
//   - A single-bit frame (in_last on the first bit) is legal; with TAIL_EN it produces 7 pairs.
//   - Back-to-back frames: the first bit of the next frame is accepted the cycle after the final tail pair is loaded, when advance allows.
//   - Asynchronous reset mid-frame or mid-tail: all state clears immediately; partial output is discarded.
//     - The downstream must treat reset as a frame abort.
//   - Throughput: 1 pair/clk when out_ready is held high, including during the tail.
// CONFIGURATION
//   CONV_ENC_TAIL_EN defined:
//     - TAIL state present; zero-tail of K-1 pairs is appended after every in_last.
//     - out_last marks the final tail pair.
//   CONV_ENC_TAIL_EN undefined:
//     - No TAIL state or tail_cnt; frames end with no flush bits.
//     - out_last marks the pair for the in_last bit; sr is cleared after it.
// STRUCTURE
//   - Package conv_pkg holds:
//     - K_C=7, G0_C=7'o171, G1_C=7'o133 (shared with the bmc/acs/traceback decoder blocks);
//     - typedef pair_t (logic [1:0]);
//     - typedef enc_state_e {ENC_DATA, ENC_TAIL}.
//   - Sub-module conv_enc_parity: combinational; inputs {u,sr} and the two generators, output pair_t.
//     - It is the single definition of the tap/parity rule, so the bit ordering cannot diverge from the decoder's branch labelling.
//   - Top: handshake logic, FSM, tail_cnt (3 bits), sr register, output register.
// TESTING
//   - Impulse, TAIL_EN, out_ready=1: bits 1 (in_last=1).
//     -> pairs 11,10,11,11,00,01,11; out_last only on the 7th; sr=0 afterwards.
//   - Stream 1,0,1,1 with in_last on the 4th, TAIL_EN.
//     -> 10 pairs that match a golden model of the G0/G1 convolution on 1,0,1,1,0,0,0,0,0,0, with out_last on the 10th.
//   - Backpressure: drop out_ready for 5 cycles mid-frame.
//     -> out_pair/out_last stable; in_ready=0; no bits lost or duplicated versus the golden model.
//   - Reset asserted on the 3rd tail step.
//     -> out_valid=0 and sr=0 at once; after release, a new impulse frame reproduces the first scenario exactly.
//   - Without CONV_ENC_TAIL_EN: frames {1} then {1}.
//     -> pairs 11 (out_last=1) then 11 (out_last=1); the second frame starts from state 0.
//   - Random: 10k bits, random frame lengths, random in_valid/out_ready toggling.
//     -> scoreboard match; loopback into the Viterbi decoder recovers all info bits.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: constants and types shared by the K=7 encoder and decoder.
// Generator taps: MSB of each generator taps the current input bit.
package conv_pkg;

  localparam int K_C = 7;
  localparam logic [K_C-1:0] G0_C = 7'o171;
  localparam logic [K_C-1:0] G1_C = 7'o133;

  typedef logic [1:0] pair_t;

  typedef enum logic {
    ENC_DATA,
    ENC_TAIL
  } enc_state_e;

endpackage

// File: rtl/conv_encoder_k7_if.sv
// conv_encoder_k7_if: info-bit input and coded-pair output handshakes.
// master drives info bits and accepts pairs; slave is the encoder.
interface conv_encoder_k7_if;
  import conv_pkg::*;

  logic  in_valid;
  logic  in_ready;
  logic  in_bit;
  logic  in_last;
  logic  out_valid;
  logic  out_ready;
  pair_t out_pair;
  logic  out_last;

  modport master (
    output in_valid,
    input  in_ready,
    output in_bit,
    output in_last,
    input  out_valid,
    output out_ready,
    input  out_pair,
    input  out_last
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_bit,
    input  in_last,
    output out_valid,
    input  out_ready,
    output out_pair,
    output out_last
  );

endinterface

// File: rtl/conv_enc_parity.sv
// conv_enc_parity: tap/parity rule for one coded pair.
// pair[1] from g0, pair[0] from g1, vector is {u, sr}.
module conv_enc_parity
  import conv_pkg::*;
(
  input  logic           u,
  input  logic [K_C-2:0] sr,
  input  logic [K_C-1:0] g0,
  input  logic [K_C-1:0] g1,
  output pair_t          pair
);

  logic [K_C-1:0] vec;

  assign vec  = {u, sr};
  assign pair = {^(g0 & vec), ^(g1 & vec)};

endmodule

// File: rtl/conv_encoder_k7.sv
// conv_encoder_k7: rate-1/2 K=7 feed-forward convolutional encoder.
// Define CONV_ENC_TAIL_EN to append a K-1 zero tail after every in_last.
module conv_encoder_k7
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  conv_encoder_k7_if.slave bus
);

  localparam int SR_W = K_C - 1;

  logic [SR_W-1:0] sr_q;
  logic [SR_W-1:0] sr_d;
  logic            out_valid_q;
  pair_t           out_pair_q;
  logic            out_last_q;

  logic  advance;
  logic  in_ready;
  logic  produce;
  logic  u;
  logic  last;
  pair_t pair;

  assign advance       = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pair  = out_pair_q;
  assign bus.out_last  = out_last_q;

`ifdef CONV_ENC_TAIL_EN
  localparam logic [2:0] TAIL_LAST = 3'(K_C - 2);

  enc_state_e state_q;
  enc_state_e state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENC_DATA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // last marks the final tail step: clears sr and flags out_last
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    produce  = 1'b0;
    u        = 1'b0;
    last     = 1'b0;
    unique case (state_q)
      ENC_DATA: begin
        in_ready = advance;
        if (bus.in_valid && advance) begin
          produce = 1'b1;
          u       = bus.in_bit;
          if (bus.in_last) begin
            state_d = ENC_TAIL;
            cnt_d   = '0;
          end
        end
      end
      ENC_TAIL: begin
        if (advance) begin
          produce = 1'b1;
          if (cnt_q == TAIL_LAST) begin
            last    = 1'b1;
            cnt_d   = '0;
            state_d = ENC_DATA;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ENC_DATA;
        cnt_d   = '0;
      end
    endcase
  end
`else
  always_comb begin
    in_ready = advance;
    produce  = bus.in_valid && advance;
    u        = bus.in_bit;
    last     = bus.in_last;
  end
`endif

  conv_enc_parity u_parity (
    .u    (u),
    .sr   (sr_q),
    .g0   (G0_C),
    .g1   (G1_C),
    .pair (pair)
  );

  // the frame-final step leaves sr at 0 for the next frame
  always_comb begin
    sr_d = sr_q;
    if (produce) begin
      sr_d = last ? '0 : {u, sr_q[SR_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_pair_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      sr_q <= sr_d;
      if (advance) begin
        out_valid_q <= produce;
        if (produce) begin
          out_pair_q <= pair;
          out_last_q <= last;
        end
      end
    end
  end

endmodule
